// File: rtl/rsa_multi_en_ctrl.sv
// Start/stop sequencer for NUM_UNITS independent rsa_unit channels: enable, timed reset release, eoc/timeout reporting.
// Optional interrupt block (irq_clr/irq_status/irq) is built only when RSA_CTRL_IRQ_EN is defined.
module rsa_multi_en_ctrl #(
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned RST_HOLD  = 1
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic [NUM_UNITS-1:0] gpio_start,
  input  logic [NUM_UNITS-1:0] spi_start,
  input  logic [NUM_UNITS-1:0] gpio_stop,
  input  logic [NUM_UNITS-1:0] spi_stop,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [NUM_UNITS-1:0] eoc_rsa_unit,
  output logic [NUM_UNITS-1:0] en_rsa,
  output logic [NUM_UNITS-1:0] rst_rsa,
  output logic [NUM_UNITS-1:0] eoc,
  output logic [NUM_UNITS-1:0] busy,
  output logic [NUM_UNITS-1:0] timeout_err
`ifdef RSA_CTRL_IRQ_EN
  ,
  input  logic [NUM_UNITS-1:0] irq_clr,
  output logic [NUM_UNITS-1:0] irq_status,
  output logic                 irq
`endif
);

  // Hold counter only needs to reach RST_HOLD-1.
  localparam int unsigned HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_TMO  = 3'd4
  } state_e;

  logic [NUM_UNITS-1:0] start;
  logic [NUM_UNITS-1:0] stop;
  logic                 tmo_en;
  logic [TIMEOUT_W-1:0] tmo_last;

  assign start    = gpio_start | spi_start;
  assign stop     = gpio_stop | spi_stop;
  assign tmo_en   = (timeout_cycles != '0);
  assign tmo_last = timeout_cycles - TIMEOUT_W'(1);

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_ch
    state_e               state_q, state_d;
    logic [HCW-1:0]       hold_q, hold_d;
    logic [TIMEOUT_W-1:0] run_q, run_d;

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      run_d   = run_q;
      case (state_q)
        S_IDLE: begin
          if (start[g] && !stop[g]) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end
        end
        S_HOLD: begin
          if (stop[g]) begin
            state_d = S_IDLE;
          end else if (hold_q == HCW'(RST_HOLD - 1)) begin
            state_d = S_RUN;
            run_d   = '0;
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
        S_RUN: begin
          // Priority: abort, then completion, then timeout; counter saturates.
          if (stop[g]) begin
            state_d = S_IDLE;
          end else if (eoc_rsa_unit[g]) begin
            state_d = S_DONE;
          end else if (tmo_en && (run_q == tmo_last)) begin
            state_d = S_TMO;
          end else if (run_q != '1) begin
            run_d = run_q + TIMEOUT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_TMO:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rstb) begin
        state_q <= S_IDLE;
        hold_q  <= '0;
        run_q   <= '0;
      end else if (ena) begin
        state_q <= state_d;
        hold_q  <= hold_d;
        run_q   <= run_d;
      end
    end

    assign en_rsa[g]      = (state_q == S_HOLD) || (state_q == S_RUN) || (state_q == S_DONE);
    assign rst_rsa[g]     = (state_q == S_RUN) || (state_q == S_DONE);
    assign eoc[g]         = (state_q == S_DONE);
    assign busy[g]        = (state_q != S_IDLE);
    assign timeout_err[g] = (state_q == S_TMO);

`ifdef RSA_CTRL_IRQ_EN
    logic irq_q;
    logic irq_set;

    assign irq_set = ena && ((state_d == S_DONE) || (state_d == S_TMO));

    always_ff @(posedge clk) begin
      if (!rstb) begin
        irq_q <= 1'b0;
      end else if (irq_set) begin
        irq_q <= 1'b1;
      end else if (ena && irq_clr[g]) begin
        irq_q <= 1'b0;
      end
    end

    assign irq_status[g] = irq_q;
`endif
  end

`ifdef RSA_CTRL_IRQ_EN
  assign irq = |irq_status;
`endif

endmodule

// File: tb/tb_rsa_multi_en_ctrl.sv
// Directed bench for rsa_multi_en_ctrl: instance A (RST_HOLD=1, 16-bit timeout), instance B (RST_HOLD=3, 3-bit timeout).
// Interrupt checks are compiled only when RSA_CTRL_IRQ_EN is defined.
module tb_rsa_multi_en_ctrl;

  localparam int I = 0, H = 1, R = 2, D = 3, T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic        ena, ena_b;
  logic [1:0]  gs, ss, gp, sp, eu;
  logic [15:0] tmo;
  logic [1:0]  st_b, sp_b;
  logic [2:0]  tmo_b;
  logic [1:0]  en_a, rst_a, eoc_a, busy_a, err_a;
  logic [1:0]  en_b, rst_b, eoc_b, busy_b, err_b;
`ifdef RSA_CTRL_IRQ_EN
  logic [1:0]  irq_clr, irq_status, irq_status_b;
  logic        irq, irq_b;
`endif

  rsa_multi_en_ctrl #(.NUM_UNITS(2), .TIMEOUT_W(16), .RST_HOLD(1)) dut_a (
    .clk(clk), .rstb(rstb), .ena(ena),
    .gpio_start(gs), .spi_start(ss), .gpio_stop(gp), .spi_stop(sp),
    .timeout_cycles(tmo), .eoc_rsa_unit(eu),
    .en_rsa(en_a), .rst_rsa(rst_a), .eoc(eoc_a), .busy(busy_a), .timeout_err(err_a)
`ifdef RSA_CTRL_IRQ_EN
    , .irq_clr(irq_clr), .irq_status(irq_status), .irq(irq)
`endif
  );

  rsa_multi_en_ctrl #(.NUM_UNITS(2), .TIMEOUT_W(3), .RST_HOLD(3)) dut_b (
    .clk(clk), .rstb(rstb), .ena(ena_b),
    .gpio_start(st_b), .spi_start(2'b00), .gpio_stop(2'b00), .spi_stop(sp_b),
    .timeout_cycles(tmo_b), .eoc_rsa_unit(2'b00),
    .en_rsa(en_b), .rst_rsa(rst_b), .eoc(eoc_b), .busy(busy_b), .timeout_err(err_b)
`ifdef RSA_CTRL_IRQ_EN
    , .irq_clr(2'b00), .irq_status(irq_status_b), .irq(irq_b)
`endif
  );

  typedef struct {
    string      tag;
    logic [9:0] ea;
    logic [9:0] eb;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // {en, rst, eoc, busy, err} for one channel in a given state
  function automatic logic [4:0] dec(input int s);
    case (s)
      H:       return 5'b10010;
      R:       return 5'b11010;
      D:       return 5'b11110;
      T:       return 5'b00011;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [9:0] pk(input int s1, input int s0);
    logic [4:0] a, b;
    a = dec(s1);
    b = dec(s0);
    return {a[4], b[4], a[3], b[3], a[2], b[2], a[1], b[1], a[0], b[0]};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic cyc(input string tag, input logic [9:0] ea, input logic [9:0] eb);
    exp_t e;
    e.tag = tag;
    e.ea  = ea;
    e.eb  = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_a"}, {en_a, rst_a, eoc_a, busy_a, err_a}, e.ea);
    check({e.tag, "_b"}, {en_b, rst_b, eoc_b, busy_b, err_b}, e.eb);
  endtask

  initial begin
    logic [9:0] ii;
    ii = pk(I, I);
    rstb = 1'b0; ena = 1'b1; ena_b = 1'b1;
    gs = '0; ss = '0; gp = '0; sp = '0; eu = '0; tmo = '0;
    st_b = '0; sp_b = '0; tmo_b = '0;
`ifdef RSA_CTRL_IRQ_EN
    irq_clr = '0;
`endif
    cyc("reset", ii, ii);
    rstb = 1'b1;
    cyc("idle", ii, ii);

    // T1: one-cycle start pulse, wait with timeout disabled, completion
    ss = 2'b01;           cyc("t1_hold", pk(I, H), ii);
    ss = 2'b00;           cyc("t1_run",  pk(I, R), ii);
    for (int i = 0; i < 3; i++) cyc("t1_wait", pk(I, R), ii);
    eu = 2'b01;           cyc("t1_done", pk(I, D), ii);
    eu = 2'b00;           cyc("t1_idle", ii, ii);

    // T2: timeout of 5 run cycles on ch1
    tmo = 16'd5;
    gs = 2'b10;           cyc("t2_hold", pk(H, I), ii);
    gs = 2'b00;
    for (int i = 0; i < 5; i++) cyc("t2_run", pk(R, I), ii);
    cyc("t2_tmo",  pk(T, I), ii);
    cyc("t2_idle", ii, ii);

    // eoc on the timeout cycle: completion wins
    gs = 2'b10;           cyc("dw_hold", pk(H, I), ii);
    gs = 2'b00;
    for (int i = 0; i < 5; i++) cyc("dw_run", pk(R, I), ii);
    eu = 2'b10;           cyc("dw_done", pk(D, I), ii);
    eu = 2'b00;           cyc("dw_idle", ii, ii);
    tmo = '0;

    // T3: abort in RUN, and abort together with eoc
    gs = 2'b01;           cyc("t3_hold", pk(I, H), ii);
    gs = 2'b00;           cyc("t3_run",  pk(I, R), ii);
    gp = 2'b01;           cyc("t3_stop", ii, ii);
    gp = 2'b00;
    gs = 2'b01;           cyc("t3b_hold", pk(I, H), ii);
    gs = 2'b00;           cyc("t3b_run",  pk(I, R), ii);
    gp = 2'b01; eu = 2'b01; cyc("t3b_stop_eoc", ii, ii);
    gp = 2'b00; eu = 2'b00; cyc("t3b_idle", ii, ii);

    // start and stop together in IDLE stays idle
    ss = 2'b01; sp = 2'b01; cyc("ss_idle", ii, ii);
    ss = 2'b00; sp = 2'b00;

    // level start relaunches after DONE
    gs = 2'b01;           cyc("lv_hold", pk(I, H), ii);
    cyc("lv_run", pk(I, R), ii);
    eu = 2'b01;           cyc("lv_done", pk(I, D), ii);
    eu = 2'b00;           cyc("lv_idle", ii, ii);
    cyc("lv_rehold", pk(I, H), ii);
    gs = 2'b00;           cyc("lv_rerun", pk(I, R), ii);
    sp = 2'b01;           cyc("lv_stop", ii, ii);
    sp = 2'b00;

    // ena=0 freezes state, including an active eoc pulse
    ss = 2'b01;           cyc("fz_hold", pk(I, H), ii);
    ss = 2'b00; ena = 1'b0; cyc("fz_hold_frozen", pk(I, H), ii);
    ena = 1'b1;           cyc("fz_run", pk(I, R), ii);
    eu = 2'b01;           cyc("fz_done", pk(I, D), ii);
    eu = 2'b00; ena = 1'b0; cyc("fz_done_frozen", pk(I, D), ii);
    ena = 1'b1;           cyc("fz_idle", ii, ii);

    // T4: RST_HOLD=3 with ena toggling, then run-counter saturation on B
    st_b = 2'b01;                cyc("t4_hold", ii, pk(I, H));
    st_b = 2'b00; ena_b = 1'b0;  cyc("t4_h0", ii, pk(I, H));
    ena_b = 1'b1;                cyc("t4_h1", ii, pk(I, H));
    ena_b = 1'b0;                cyc("t4_h2", ii, pk(I, H));
    ena_b = 1'b1;                cyc("t4_h3", ii, pk(I, H));
    ena_b = 1'b0;                cyc("t4_h4", ii, pk(I, H));
    ena_b = 1'b1;                cyc("t4_run", ii, pk(I, R));
    ena_b = 1'b0;                cyc("t4_run_frozen", ii, pk(I, R));
    ena_b = 1'b1;
    for (int i = 0; i < 9; i++) cyc("sat_run", ii, pk(I, R));
    // counter now pinned at 7, so a timeout of 3 can never match
    tmo_b = 3'd3;
    for (int i = 0; i < 8; i++) cyc("sat_hold", ii, pk(I, R));
    sp_b = 2'b01;                cyc("sat_stop", ii, ii);
    sp_b = 2'b00; tmo_b = '0;

    // T5: reset mid-conversion on both channels, then restart
    gs = 2'b11;           cyc("t5_hold", pk(H, H), ii);
    gs = 2'b00;           cyc("t5_run",  pk(R, R), ii);
    cyc("t5_run2", pk(R, R), ii);
    rstb = 1'b0;          cyc("t5_reset", ii, ii);
    rstb = 1'b1;          cyc("t5_idle", ii, ii);
    ss = 2'b01;           cyc("t5_rehold", pk(I, H), ii);
    ss = 2'b00;           cyc("t5_rerun",  pk(I, R), ii);
    eu = 2'b01;           cyc("t5_done",   pk(I, D), ii);
    eu = 2'b00;           cyc("t5_fin",    ii, ii);

`ifdef RSA_CTRL_IRQ_EN
    // T6: eoc on ch0, timeout on ch1, then partial clear
    irq_clr = 2'b11;      cyc("t6_clr_all", ii, ii);
    irq_clr = 2'b00;
    check("t6_status0", {8'd0, irq_status}, 10'd0);
    tmo = 16'd2;
    gs = 2'b11;           cyc("t6_hold", pk(H, H), ii);
    gs = 2'b00;           cyc("t6_run",  pk(R, R), ii);
    eu = 2'b01;           cyc("t6_done", pk(R, D), ii);
    check("t6_status_d", {8'd0, irq_status}, 10'd1);
    eu = 2'b00;           cyc("t6_tmo",  pk(T, I), ii);
    cyc("t6_idle", ii, ii);
    check("t6_status11", {8'd0, irq_status}, 10'd3);
    check("t6_irq", {9'd0, irq}, 10'd1);
    irq_clr = 2'b01;      cyc("t6_clr0", ii, ii);
    irq_clr = 2'b00;
    check("t6_status10", {8'd0, irq_status}, 10'd2);
    check("t6_irq_hold", {9'd0, irq}, 10'd1);
    tmo = '0;
`endif

    check("sb_empty", 10'(sb.size()), 10'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
